// File: rtl/q_8_34a_ctrl.sv
// Control FSM for a ones-counter datapath: sequences load/increment/shift
// commands, reports completion, and records how many cycles the last operation took.
module q_8_34a_ctrl #(
  parameter int data_size = 8,
  parameter int cyc_size  = 6
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                start,
  input  logic                abort,
  input  logic                zero,
  input  logic                E,
  output logic                load_regs,
  output logic                incr_r2,
  output logic                shift,
  output logic                busy,
  output logic                done,
  output logic [cyc_size-1:0] cycles
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_1    = 2'd1;
  localparam logic [1:0] S_2    = 2'd2;
  localparam logic [1:0] S_3    = 2'd3;

  // Worst case is every bit a one: 3 + 3 cycles per bit.
  localparam int MAX_CYC = 3 + 3 * data_size;

  logic [1:0]          state_q, state_d;
  logic [cyc_size-1:0] cnt_q, cnt_d, cnt_inc;
  logic [cyc_size-1:0] cycles_q, cycles_d;
  logic                done_q, done_d;
  logic                accept, finish;

  assign accept  = (state_q == S_IDLE) && start && !abort;
  assign finish  = (state_q == S_2) && zero && !abort;
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + cyc_size'(1);

  assign load_regs = accept;
  assign incr_r2   = (state_q == S_1) && !abort;
  assign shift     = (state_q == S_2) && !zero && !abort;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign cycles    = cycles_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_1;
      S_1:     state_d = S_2;
      S_2:     state_d = zero ? S_IDLE : S_3;
      S_3:     state_d = E ? S_1 : S_2;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Counter starts at 1 so the accept cycle itself is included in the count.
  always_comb begin
    cnt_d = cnt_q;
    if (accept)    cnt_d = cyc_size'(1);
    else if (busy) cnt_d = cnt_inc;
  end

  assign cycles_d = finish ? cnt_inc : cycles_q;
  assign done_d   = finish;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      cycles_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
    end
  end

  a_cmd_onehot: assert property (@(posedge clk) disable iff (!rst_b)
    $onehot0({load_regs, incr_r2, shift}));

  a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_b)
    busy |-> (int'(cnt_q) <= MAX_CYC));

endmodule

// File: tb/tb_q_8_34a_ctrl.sv
// Bench for q_8_34a_ctrl: a behavioural r1/r2 datapath closes the loop, and a
// bit-walk reference model predicts the per-cycle command trace, done and cycles.
module tb_q_8_34a_ctrl;
  logic       clk = 1'b0;
  logic       rst_b, start, abort, zero, E;
  logic       load_regs, incr_r2, shift, busy, done;
  logic [5:0] cycles;
  logic       load_s, incr_s, shift_s, busy_s, done_s;
  logic [3:0] cycles_s;
  logic [7:0] data_in = 8'h00;
  logic [7:0] r1 = 8'h00, r2 = 8'h00;
  logic       e_q = 1'b0;

  int n_tests = 0, n_fail = 0;
  int tr_q[$];
  logic [5:0] exp_cyc;
  logic [3:0] exp_cyc_s;

  localparam int C_NONE = 0, C_LOAD = 1, C_INCR = 2, C_SHIFT = 3;

  q_8_34a_ctrl dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .zero(zero), .E(E),
    .load_regs(load_regs), .incr_r2(incr_r2), .shift(shift), .busy(busy),
    .done(done), .cycles(cycles));

  q_8_34a_ctrl #(.data_size(8), .cyc_size(4)) dut_s (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .zero(zero), .E(E),
    .load_regs(load_s), .incr_r2(incr_s), .shift(shift_s), .busy(busy_s),
    .done(done_s), .cycles(cycles_s));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load_regs) begin
      r1 <= data_in;
      r2 <= 8'hFF;
    end else if (incr_r2) r2 <= r2 + 8'd1;
    else if (shift) {e_q, r1} <= {e_q, r1} << 1;
  end
  assign zero = (r1 == 8'h00);
  assign E    = e_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the operand MSB-first until no ones remain.
  function automatic void build_trace(input logic [7:0] d);
    logic [7:0] r;
    logic       b;
    tr_q.delete();
    tr_q.push_back(C_LOAD);
    tr_q.push_back(C_INCR);
    r = d;
    forever begin
      if (r == 8'h00) begin
        tr_q.push_back(C_NONE);
        break;
      end
      tr_q.push_back(C_SHIFT);
      b = r[7];
      r = r << 1;
      tr_q.push_back(C_NONE);
      if (b) tr_q.push_back(C_INCR);
    end
  endfunction

  function automatic logic [4:0] cmd_vec(input int c, input logic bsy, input logic dn);
    return {c == C_LOAD, c == C_INCR, c == C_SHIFT, bsy, dn};
  endfunction

  // Caller is positioned 1 time unit after a rising edge; returns likewise.
  task automatic run_op(input logic [7:0] d, input int exp_l, input int ab_at,
                        input int st_at, input logic [7:0] exp_r2);
    logic [4:0] ev;
    int         end_k;
    build_trace(d);
    end_k   = (ab_at > 0) ? ab_at + 2 : exp_l + 1;
    data_in = d;
    for (int k = 0; k <= end_k; k++) begin
      start = (k == 0) || (k == st_at);
      abort = (k == ab_at);
      @(negedge clk);
      if (ab_at > 0 && k == ab_at)      ev = cmd_vec(C_NONE, 1'b1, 1'b0);
      else if (ab_at > 0 && k > ab_at)  ev = cmd_vec(C_NONE, 1'b0, 1'b0);
      else if (k < tr_q.size())         ev = cmd_vec(tr_q[k], k != 0, 1'b0);
      else if (k == exp_l)              ev = cmd_vec(C_NONE, 1'b0, 1'b1);
      else                              ev = cmd_vec(C_NONE, 1'b0, 1'b0);
      chk($sformatf("cmd d=%02h k=%0d", d, k), {27'b0, load_regs, incr_r2, shift, busy, done}, {27'b0, ev});
      chk($sformatf("cmd_s d=%02h k=%0d", d, k), {27'b0, load_s, incr_s, shift_s, busy_s, done_s}, {27'b0, ev});
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    if (ab_at <= 0) begin
      exp_cyc   = 6'(exp_l);
      exp_cyc_s = (exp_l > 15) ? 4'd15 : 4'(exp_l);
      chk($sformatf("r2 d=%02h", d), {24'b0, r2}, {24'b0, exp_r2});
    end
    chk($sformatf("cycles d=%02h", d), {26'b0, cycles}, {26'b0, exp_cyc});
    chk($sformatf("cycles_s d=%02h", d), {28'b0, cycles_s}, {28'b0, exp_cyc_s});
  endtask

  typedef struct {
    logic [7:0] d;
    int         exp_l;
    int         ab_at;
    int         st_at;
    logic [7:0] exp_r2;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs = '{
      '{8'h00,  3, -1, -1, 8'd0},
      '{8'h80,  6, -1,  2, 8'd1},
      '{8'h01, 20, -1,  7, 8'd1},
      '{8'hFF, 27, -1, -1, 8'd8},
      '{8'hAA, 21, -1, -1, 8'd4},
      '{8'h55, 23, -1, 10, 8'd4},
      '{8'hFF, 27,  5,  3, 8'd0},
      '{8'h01, 20, 19, -1, 8'd0}
    };
    exp_cyc   = 6'd0;
    exp_cyc_s = 4'd0;
    start = 1'b1;
    abort = 1'b0;
    rst_b = 1'b0;
    #2;
    chk("reset state", {28'b0, busy, done, busy_s, done_s}, 32'd0);
    chk("reset cycles", {26'b0, cycles}, 32'd0);
    chk("reset load follows start", {31'b0, load_regs}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset holds idle", {30'b0, busy, done}, 32'd0);
    start = 1'b0;
    rst_b = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_op(vecs[i].d, vecs[i].exp_l, vecs[i].ab_at, vecs[i].st_at, vecs[i].exp_r2);

    // abort beats start while idle
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    chk("idle abort+start load", {31'b0, load_regs}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("idle abort+start busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;

    // reset mid-operation discards it; next start accepted at first edge
    data_in = 8'hFF;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_b = 1'b0;
    #1;
    chk("midop reset flags", {30'b0, busy, done}, 32'd0);
    chk("midop reset cycles", {26'b0, cycles}, 32'd0);
    chk("midop reset cycles_s", {28'b0, cycles_s}, 32'd0);
    exp_cyc   = 6'd0;
    exp_cyc_s = 4'd0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    run_op(8'h00, 3, -1, -1, 8'd0);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      int l, ab, st, last, gap;
      d = 8'($urandom);
      build_trace(d);
      l    = tr_q.size();
      ab   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, l - 1)) : -1;
      last = (ab > 0) ? ab : l - 1;
      st   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, last)) : -1;
      gap  = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        abort = ($urandom_range(0, 1) == 1);
        @(posedge clk); #1;
      end
      abort = 1'b0;
      run_op(d, l, ab, st, 8'($countones(d)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
